// File: rtl/wrf_frame_gen_if.sv
// Wishbone B4 pipelined WR-fabric link, 16-bit data.
// The master drives cyc/stb/we/sel/adr/dat; the slave answers with stall/ack/err.
interface wrf_frame_gen_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  sel;
  logic [1:0]  adr;
  logic [15:0] dat;
  logic        stall;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, sel, adr, dat, input stall, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, dat, output stall, ack, err);
endinterface

// File: rtl/wrf_frame_gen.sv
// Ethernet test-frame source: status word, header and LFSR payload on a WR-fabric master.
// Optional macro WRF_GEN_TIMEOUT_EN aborts a frame after g_timeout cycles without ack or accept.
module wrf_frame_gen #(
  parameter logic [47:0] g_dst_mac         = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] g_src_mac         = 48'h010203040506,
  parameter int unsigned g_max_outstanding = 8,
  parameter int unsigned g_timeout         = 1024
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [10:0]     len_i,
  input  logic [15:0]     seed_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [31:0]     frame_cnt_o,
  wrf_frame_gen_if.master src
);
  localparam logic [3:0]  OUTST_MAX = 4'(g_max_outstanding);
  localparam logic [10:0] LEN_MIN   = 11'd46;
  localparam logic [10:0] LEN_MAX   = 11'd1500;

  if (g_max_outstanding < 1 || g_max_outstanding > 15 || g_timeout < 1) begin : g_param_check
    $error("wrf_frame_gen: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_STATUS, S_HDR, S_PAY, S_WAIT_ACK} state_t;

  state_t      state_reg;
  logic        cyc_reg, stb_req_reg, busy_reg, done_reg, err_reg, abort_reg;
  logic [1:0]  sel_reg, adr_reg;
  logic [15:0] dat_reg, lfsr_reg;
  logic [10:0] len_reg;
  logic [2:0]  hdr_idx_reg;
  logic [9:0]  pay_left_reg;
  logic [3:0]  outst_reg, outst_next;
  logic [31:0] frame_cnt_reg;

  logic        stb_int, accept, ack_valid, tmo_hit, finish_now;
  logic [10:0] len_clamped;
  logic [15:0] seed_eff, lfsr_next;
  logic [9:0]  pay_words;
  logic [15:0] hdr_words [0:6];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hdr
      assign hdr_words[gi]     = g_dst_mac[47 - 16*gi -: 16];
      assign hdr_words[gi + 3] = g_src_mac[47 - 16*gi -: 16];
    end
  endgenerate
  assign hdr_words[6] = {5'd0, len_reg};

  always_comb begin
    len_clamped = len_i;
    if (len_i < LEN_MIN)
      len_clamped = LEN_MIN;
    else if (len_i > LEN_MAX)
      len_clamped = LEN_MAX;
  end

  assign seed_eff  = (seed_i == 16'd0) ? 16'hACE1 : seed_i;
  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign pay_words = 10'((12'(len_reg) + 12'd1) >> 1);

  // stb is masked rather than registered so the pipeline refills the cycle after an ack frees a slot
  assign stb_int   = stb_req_reg && (outst_reg != OUTST_MAX);
  assign accept    = stb_int && !src.stall;
  assign ack_valid = src.ack && (outst_reg != 4'd0);

  always_comb begin
    outst_next = outst_reg;
    case ({accept, ack_valid})
      2'b10:   outst_next = outst_reg + 4'd1;
      2'b01:   outst_next = outst_reg - 4'd1;
      default: outst_next = outst_reg;
    endcase
  end

`ifdef WRF_GEN_TIMEOUT_EN
  logic [31:0] tmo_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !cyc_reg || accept || src.ack)
      tmo_reg <= 32'(g_timeout);
    else if (tmo_reg != 32'd0)
      tmo_reg <= tmo_reg - 32'd1;
  end

  assign tmo_hit = cyc_reg && !accept && !src.ack && (tmo_reg == 32'd1);
`else
  assign tmo_hit = 1'b0;
`endif

  // an aborted frame closes the cycle without waiting for the remaining acks
  assign finish_now = tmo_hit ||
                      (state_reg == S_WAIT_ACK && (abort_reg || outst_reg == 4'd0 || src.err));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg     <= S_IDLE;
      cyc_reg       <= 1'b0;
      stb_req_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      abort_reg     <= 1'b0;
      sel_reg       <= 2'b11;
      adr_reg       <= 2'b00;
      dat_reg       <= 16'd0;
      lfsr_reg      <= 16'hACE1;
      len_reg       <= LEN_MIN;
      hdr_idx_reg   <= 3'd0;
      pay_left_reg  <= 10'd0;
      outst_reg     <= 4'd0;
      frame_cnt_reg <= 32'd0;
    end else begin
      done_reg  <= 1'b0;
      outst_reg <= outst_next;

      case (state_reg)
        S_IDLE: begin
          if (start_i && !done_reg) begin
            len_reg     <= len_clamped;
            lfsr_reg    <= seed_eff;
            busy_reg    <= 1'b1;
            err_reg     <= 1'b0;
            abort_reg   <= 1'b0;
            cyc_reg     <= 1'b1;
            stb_req_reg <= 1'b1;
            adr_reg     <= 2'b10;
            sel_reg     <= 2'b11;
            dat_reg     <= 16'h0000;
            state_reg   <= S_STATUS;
          end
        end
        S_STATUS: begin
          if (accept) begin
            adr_reg     <= 2'b00;
            dat_reg     <= hdr_words[0];
            hdr_idx_reg <= 3'd0;
            state_reg   <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept) begin
            if (hdr_idx_reg == 3'd6) begin
              dat_reg      <= lfsr_reg;
              pay_left_reg <= pay_words;
              state_reg    <= S_PAY;
            end else begin
              hdr_idx_reg <= hdr_idx_reg + 3'd1;
              dat_reg     <= hdr_words[hdr_idx_reg + 3'd1];
            end
          end
        end
        S_PAY: begin
          if (accept) begin
            lfsr_reg <= lfsr_next;
            if (pay_left_reg == 10'd1) begin
              stb_req_reg <= 1'b0;
              state_reg   <= S_WAIT_ACK;
            end else begin
              pay_left_reg <= pay_left_reg - 10'd1;
              // an odd length ends on a half word carried in the upper byte lane
              if (pay_left_reg == 10'd2 && len_reg[0]) begin
                sel_reg <= 2'b10;
                dat_reg <= {lfsr_next[15:8], 8'h00};
              end else begin
                dat_reg <= lfsr_next;
              end
            end
          end
        end
        default: ;
      endcase

      if (finish_now) begin
        cyc_reg     <= 1'b0;
        stb_req_reg <= 1'b0;
        busy_reg    <= 1'b0;
        done_reg    <= 1'b1;
        abort_reg   <= 1'b0;
        outst_reg   <= 4'd0;
        sel_reg     <= 2'b11;
        state_reg   <= S_IDLE;
        err_reg     <= err_reg | src.err | tmo_hit;
        if (!(err_reg || src.err || tmo_hit))
          frame_cnt_reg <= frame_cnt_reg + 32'd1;
      end else if (src.err && state_reg != S_IDLE) begin
        err_reg     <= 1'b1;
        abort_reg   <= 1'b1;
        stb_req_reg <= 1'b0;
        state_reg   <= S_WAIT_ACK;
      end
    end
  end

  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign frame_cnt_o = frame_cnt_reg;

  assign src.cyc = cyc_reg;
  assign src.stb = stb_int;
  assign src.we  = 1'b1;
  assign src.sel = sel_reg;
  assign src.adr = adr_reg;
  assign src.dat = dat_reg;
endmodule

// File: tb/tb_wrf_frame_gen.sv
// Directed bench for wrf_frame_gen: scoreboarded fabric words plus a stalling/acking fabric slave.
module tb_wrf_frame_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] len = 11'd0;
  logic [15:0] seed = 16'd0;
  logic        busy, done, err;
  logic [31:0] frame_cnt;

  wrf_frame_gen_if bus();

  wrf_frame_gen dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .len_i       (len),
    .seed_i      (seed),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .frame_cnt_o (frame_cnt),
    .src         (bus)
  );

  localparam logic [47:0] DST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC = 48'h010203040506;

  int n_pass = 0, n_total = 0, n_fail = 0;
  logic [19:0] exp_q[$];
  int ack_pend[$];
  int cyc_num = 0, acc_cnt = 0, ack_cnt = 0, done_cnt = 0;
  int acks_at_drop = 0, drop_cyc = 0, err_cyc = 0, err_at = 0;
  int ack_delay = 1, stall_pct = 0;
  bit ack_hold = 1'b0;
  logic [19:0] cap [16];
  logic [19:0] last_word = 20'd0;

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Expected fabric words as {adr, sel, dat}
  task automatic push_expected(input logic [10:0] l_in, input logic [15:0] s_in);
    logic [10:0] l;
    logic [15:0] s;
    logic [47:0] dmac, smac;
    int nw;
    l = (l_in < 11'd46) ? 11'd46 : ((l_in > 11'd1500) ? 11'd1500 : l_in);
    s = (s_in == 16'd0) ? 16'hACE1 : s_in;
    dmac = DST;
    smac = SRC;
    exp_q.push_back({2'b10, 2'b11, 16'h0000});
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 2'b11, dmac[47 - 16*i -: 16]});
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 2'b11, smac[47 - 16*i -: 16]});
    exp_q.push_back({2'b00, 2'b11, 5'd0, l});
    nw = (int'(l) + 1) / 2;
    for (int i = 0; i < nw; i++) begin
      if (i == nw - 1 && l[0]) exp_q.push_back({2'b00, 2'b10, s[15:8], 8'h00});
      else                     exp_q.push_back({2'b00, 2'b11, s});
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
  endtask

  task automatic start_frame(input logic [10:0] l, input logic [15:0] s);
    push_expected(l, s);
    acc_cnt = 0;
    ack_cnt = 0;
    @(posedge clk); #1;
    len = l; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Fabric slave: random stall, delayed in-order acks, optional error pulse on a chosen accept
  initial begin : responder
    bit st;
    bus.stall = 1'b0; bus.ack = 1'b0; bus.err = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc_num++;
      st = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
      bus.stall = st;
      bus.ack = 1'b0;
      if (!ack_hold && ack_pend.size() > 0 && cyc_num >= ack_pend[0] + ack_delay) begin
        void'(ack_pend.pop_front());
        bus.ack = 1'b1;
      end
      bus.err = 1'b0;
      if (err_at > 0 && bus.stb === 1'b1 && !st && acc_cnt + 1 == err_at) begin
        bus.err = 1'b1;
        err_cyc = cyc_num;
        err_at = 0;
      end
    end
  end

  // Monitor: compares every accepted word with the scoreboard and checks hold-during-stall
  initial begin : monitor
    logic [19:0] word, prev_word;
    bit prev_hold;
    logic prev_cyc;
    prev_hold = 1'b0;
    prev_cyc = 1'b0;
    prev_word = 20'd0;
    forever begin
      @(negedge clk);
      word = {bus.adr, bus.sel, bus.dat};
      if (prev_hold && bus.stb === 1'b1) chk("stall_hold", 32'(word), 32'(prev_word));
      if (bus.stb === 1'b1 && bus.stall === 1'b0) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        else chk($sformatf("word%0d", acc_cnt), 32'(word), 32'(exp_q.pop_front()));
        if (acc_cnt < 16) cap[acc_cnt] = word;
        last_word = word;
        acc_cnt++;
        ack_pend.push_back(cyc_num);
      end
      if (bus.ack === 1'b1) ack_cnt++;
      if (done === 1'b1) done_cnt++;
      if (prev_cyc === 1'b1 && bus.cyc === 1'b0) begin
        acks_at_drop = ack_cnt;
        drop_cyc = cyc_num;
      end
      prev_hold = (bus.stb === 1'b1 && bus.stall === 1'b1);
      prev_word = word;
      prev_cyc = bus.cyc;
    end
  end

  initial begin : stimulus
    int done0, fc0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    chk("rst_cyc", 32'(bus.cyc), 32'd0);
    chk("rst_stb", 32'(bus.stb), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd1);
    chk("rst_sel", 32'(bus.sel), 32'd3);

    // len=46, seed=1, no stall, ack one cycle after accept
    done0 = done_cnt;
    start_frame(11'd46, 16'd1);
    wait_done(500, "f46");
    settle();
    chk("f46_strobes", 32'(acc_cnt), 32'd31);
    chk("f46_status_word", 32'(cap[0]), 32'h B0000);
    chk("f46_ethertype", 32'(cap[7][15:0]), 32'h002E);
    chk("f46_pay0", 32'(cap[8][15:0]), 32'h0001);
    chk("f46_pay1", 32'(cap[9][15:0]), 32'h0002);
    chk("f46_done_pulses", 32'(done_cnt - done0), 32'd1);
    chk("f46_frame_cnt", frame_cnt, 32'd1);
    chk("f46_acks_at_drop", 32'(acks_at_drop), 32'd31);
    chk("f46_sb_empty", 32'(exp_q.size()), 32'd0);

    // len=47, 50% stall, acks three cycles late
    stall_pct = 50; ack_delay = 3;
    start_frame(11'd47, 16'($urandom));
    wait_done(3000, "f47");
    settle();
    chk("f47_strobes", 32'(acc_cnt), 32'd32);
    chk("f47_last_sel", 32'(last_word[17:16]), 32'd2);
    chk("f47_last_lo_byte", 32'(last_word[7:0]), 32'd0);
    chk("f47_acks_at_drop", 32'(acks_at_drop), 32'd32);
    chk("f47_frame_cnt", frame_cnt, 32'd2);
    chk("f47_sb_empty", 32'(exp_q.size()), 32'd0);
    stall_pct = 0; ack_delay = 1;

    // Acks withheld: strobing stops at the outstanding limit, resumes on ack
    ack_hold = 1'b1;
    start_frame(11'd46, 16'h5A5A);
    repeat (25) @(posedge clk);
    #1;
    chk("hold_accepts", 32'(acc_cnt), 32'd8);
    chk("hold_stb_low", 32'(bus.stb), 32'd0);
    chk("hold_cyc_high", 32'(bus.cyc), 32'd1);
    ack_hold = 1'b0;
    wait_done(500, "hold");
    settle();
    chk("hold_strobes", 32'(acc_cnt), 32'd31);
    chk("hold_frame_cnt", frame_cnt, 32'd3);

    // Fabric error on the 5th accept aborts the frame
    done0 = done_cnt; fc0 = int'(frame_cnt);
    err_at = 5;
    start_frame(11'd46, 16'h00FF);
    wait_done(200, "abort");
    settle();
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_cyc_drop_latency", 32'((drop_cyc - err_cyc) >= 1 && (drop_cyc - err_cyc) <= 2), 32'd1);
    chk("abort_strobes", 32'(acc_cnt), 32'd5);
    chk("abort_done_pulses", 32'(done_cnt - done0), 32'd1);
    chk("abort_frame_cnt", frame_cnt, 32'(fc0));
    exp_q.delete();
    ack_pend.delete();
    start_frame(11'd46, 16'h1111);
    chk("err_cleared_by_start", 32'(err), 32'd0);
    wait_done(500, "after_abort");
    settle();
    chk("after_abort_frame_cnt", frame_cnt, 32'(fc0 + 1));

    // len=2000 clamps to 1500; start while busy and start during done are ignored
    start_frame(11'd2000, 16'hBEEF);
    repeat (50) @(posedge clk);
    #1 len = 11'd10; seed = 16'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(3000, "f2000");
    len = 11'd10; seed = 16'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_in_done_cycle_busy", 32'(busy), 32'd0);
    settle();
    chk("f2000_strobes", 32'(acc_cnt), 32'd758);
    chk("f2000_ethertype", 32'(cap[7][15:0]), 32'h05DC);
    chk("f2000_frame_cnt", frame_cnt, 32'(fc0 + 2));
    start_frame(11'd10, 16'd0);
    wait_done(500, "f10");
    settle();
    chk("f10_strobes", 32'(acc_cnt), 32'd31);
    chk("f10_ethertype", 32'(cap[7][15:0]), 32'h002E);
    chk("f10_pay0_seed0", 32'(cap[8][15:0]), 32'hACE1);
    chk("f10_frame_cnt", frame_cnt, 32'(fc0 + 3));

    // Reset mid-frame: bus released at the next edge, no done pulse
    done0 = done_cnt;
    start_frame(11'd46, 16'h2222);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cyc", 32'(bus.cyc), 32'd0);
    chk("midrst_stb", 32'(bus.stb), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_cnt", frame_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    ack_pend.delete();
    settle();
    chk("midrst_no_done", 32'(done_cnt - done0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wrf_frame_gen.md
Name: wrf_frame_gen

Overview:
- Hardware Ethernet frame generator driving a 16-bit pipelined WR-fabric source (Wishbone B4 pipelined master).
- Transmit-side counterpart to the fabric packet sink/checker used around the FEC encoder/decoder chain.
- Emits status word, Ethernet header and an LFSR-derived payload so a downstream checker can regenerate and compare it.
- Sits in front of the FEC encoder sink (or the loopback/dropper path) for on-chip traffic and latency measurement.

Parameters:
- g_dst_mac, 48'hFFFFFFFFFFFF, destination MAC placed in header.
- g_src_mac, 48'h010203040506, source MAC placed in header.
- g_max_outstanding, 8, maximum accepted-but-unacked strobes (1..15).
- g_timeout, 1024, ack-wait timeout in clk_i cycles (used only with WRF_GEN_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  synchronous active-low reset.
- start_i  in  1  one-cycle request to send one frame; ignored while busy_o=1.
- len_i  in  11  payload length in bytes, sampled at start; clamped to 46..1500.
- seed_i  in  16  LFSR seed, sampled at start; 0 is replaced by 16'hACE1.
- busy_o  out  1  high from accepted start until the frame ends.
- done_o  out  1  one-cycle pulse at frame end.
- err_o  out  1  sticky error flag, cleared by the next accepted start.
- frame_cnt_o  out  32  frames completed without error; wraps.
- src_cyc_o  out  1  fabric cycle.
- src_stb_o  out  1  fabric strobe.
- src_we_o  out  1  constant 1.
- src_sel_o  out  2  byte select.
- src_adr_o  out  2  00 data, 10 status.
- src_dat_o  out  16  fabric data.
- src_stall_i  in  1  fabric stall.
- src_ack_i  in  1  fabric ack.
- src_err_i  in  1  fabric error.

Behaviour:
- Reset values: all outputs 0 except src_we_o=1, src_sel_o=2'b11; FSM IDLE; frame_cnt_o=0.
- Reset asserted mid-frame: cyc/stb drop on the next edge; no done_o is generated.
- Transfer rule: a word is accepted when stb=1 and stall=0; the next word is presented the following cycle.
- While stalled, dat/adr/sel hold.
- Outstanding counter: +1 on accept, -1 on ack; both in one cycle leaves it unchanged.
- stb is deasserted whenever outstanding = g_max_outstanding.
- FSM sequence: IDLE -> STATUS -> HDR -> PAY -> WAIT_ACK -> IDLE.
  - IDLE -> STATUS: start_i=1. Latch len (clamped) and seed; busy_o=1; cyc=stb=1 in the same transition cycle's next state.
  - STATUS: one word, adr=10, dat=16'h0000.
  - HDR: 7 words, adr=00: dst[47:32], dst[31:16], dst[15:0], src (same order), then ethertype = clamped len zero-extended to 16 bits.
  - PAY: ceil(len/2) words, each word = current LFSR state. LFSR advances on each accepted payload word: Fibonacci x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  - Odd len: last word has sel=2'b10 and dat[7:0]=0.
  - WAIT_ACK: stb=0, cyc=1 until outstanding=0; then cyc=0, done_o=1 pulse, frame_cnt_o+1, busy_o=0, return to IDLE.
- Total strobes per frame = 8 + ceil(len/2).
- src_err_i in any non-IDLE state:
  - Set err_o; stop strobing; enter WAIT_ACK; drop cyc on the next cycle regardless of outstanding.
  - done_o still pulses; frame_cnt_o is not incremented.
- Ack with zero outstanding: ignored; counter saturates at 0.
- start_i while busy: ignored, no queueing.
- start_i in the same cycle as done_o: ignored; busy_o must be low in the cycle start_i is sampled.

Optional Feature:
- Macro: WRF_GEN_TIMEOUT_EN.
- Defined:
  - Counter reloads to g_timeout on every ack and every accept while cyc=1; decrements otherwise.
  - On reaching 0: err_o=1, cyc/stb drop next cycle, done_o pulses, outstanding cleared, frame not counted.
- Undefined: no counter; the block waits indefinitely for acks.

Test Plan:
- Reset, start_i with len=46, seed=1, no stall, ack 1 cycle after each accept -> 31 strobes; first word adr=10 dat=0000; word 7 = 002E; first payload word 0001, second 0002; done_o once; frame_cnt_o=1.
- len=47, random stall 50%, acks delayed 3 cycles -> 32 strobes; last word sel=10 with dat[7:0]=00; data held stable during stall; cyc drops only after the 32nd ack.
- Ack withheld entirely, g_max_outstanding=8 -> stb drops after exactly 8 accepts; resumes when acks return.
- src_err_i pulsed on the 5th accept -> err_o=1, cyc=0 within 2 cycles, done_o pulse, frame_cnt_o unchanged; next start clears err_o.
- len=2000, then len=10 -> ethertype 05DC with 758 strobes, then 002E with 31 strobes; start_i pulsed while busy has no effect.
- With WRF_GEN_TIMEOUT_EN and g_timeout=16, acks stopped mid-payload -> err_o=1 and cyc=0 exactly 16 idle cycles after the last ack or accept.
